// File: rtl/clock_pkg.sv
// Shared clock-chain definitions: set-mode state encoding, field limits and widths
// common to the seconds, minute and hour stages.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } set_state_t;

  localparam int SEC_BIT  = 6;
  localparam int MIN_BIT  = 6;
  localparam int HOUR_BIT = 5;

  localparam int MIN_MAX     = 59;
  localparam int HOUR_MAX_24 = 23;
  localparam int HOUR_MAX_12 = 12;

endpackage

// File: rtl/wrap_counter.sv
// Generic modulo counter: steps on inc and returns to MIN_VAL once at MAX_VAL;
// anything at or above MAX_VAL is treated as the wrap point.
module wrap_counter #(
  parameter int WIDTH     = 6,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 59,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] FIRST_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] LAST_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

  assign wrap = (count >= LAST_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RESET_V;
    end else if (inc) begin
      count <= wrap ? FIRST_V : count + 1'b1;
    end
  end

endmodule

// File: rtl/min_hour_gen.sv
// Minute/hour stage with the hour-then-minute time-set FSM.
// Define HOUR_12_MODE_EN for a 1..12 hour range with a pm output.
module min_hour_gen
  import clock_pkg::*;
#(
  parameter int P_MIN_BIT  = MIN_BIT,
  parameter int P_HOUR_BIT = HOUR_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  one_sec_tick,
  input  logic                  min_tic,
  input  logic                  mode_btn,
  input  logic                  inc_btn,
  output logic [P_MIN_BIT-1:0]  min,
  output logic [P_HOUR_BIT-1:0] hour,
  output logic [1:0]            set_state,
  output logic                  sec_clr,
  output logic                  hour_tic,
  output logic                  day_tic
`ifdef HOUR_12_MODE_EN
  , output logic                pm
`endif
);

`ifdef HOUR_12_MODE_EN
  localparam int HOUR_FIRST = 1;
  localparam int HOUR_LAST  = HOUR_MAX_12;
  localparam int HOUR_RESET = HOUR_MAX_12;
`else
  localparam int HOUR_FIRST = 0;
  localparam int HOUR_LAST  = HOUR_MAX_24;
  localparam int HOUR_RESET = 0;
`endif

  localparam logic [P_MIN_BIT-1:0] MIN_LAST = P_MIN_BIT'(MIN_MAX);

  set_state_t state;
  logic       in_set_hour, in_set_min, in_run;
  logic       run_adv, min_inc, hour_inc;
  logic       min_wrap, hour_wrap;

  assign in_set_hour = (state == SET_HOUR);
  assign in_set_min  = (state == SET_MIN);
  assign in_run      = !in_set_hour && !in_set_min;

  // The minute-wrap level only counts in the single cycle the second tick qualifies it.
  assign run_adv  = in_run && en && one_sec_tick && min_tic;
  assign min_inc  = run_adv || (in_set_min && inc_btn);
  assign hour_inc = (run_adv && min_wrap) || (in_set_hour && inc_btn);

  assign set_state = state;
  assign hour_tic  = min_tic && (min == MIN_LAST);

  wrap_counter #(
    .WIDTH(P_MIN_BIT), .MIN_VAL(0), .MAX_VAL(MIN_MAX), .RESET_VAL(0)
  ) u_min_cnt (
    .clk(clk), .reset(reset), .inc(min_inc), .count(min), .wrap(min_wrap)
  );

  wrap_counter #(
    .WIDTH(P_HOUR_BIT), .MIN_VAL(HOUR_FIRST), .MAX_VAL(HOUR_LAST), .RESET_VAL(HOUR_RESET)
  ) u_hour_cnt (
    .clk(clk), .reset(reset), .inc(hour_inc), .count(hour), .wrap(hour_wrap)
  );

`ifdef HOUR_12_MODE_EN
  localparam logic [P_HOUR_BIT-1:0] HOUR_ELEVEN = P_HOUR_BIT'(11);

  assign day_tic = hour_tic && (hour == HOUR_ELEVEN) && pm && !hour_wrap;

  // Only running time crosses noon/midnight; setting the hour never flips pm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pm <= 1'b0;
    end else if (run_adv && min_wrap && (hour == HOUR_ELEVEN)) begin
      pm <= ~pm;
    end
  end
`else
  assign day_tic = hour_tic && hour_wrap;
`endif

  // Unused encoding 2'd3 behaves as RUN and falls back to it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      sec_clr <= 1'b0;
    end else begin
      sec_clr <= 1'b0;
      case (state)
        SET_HOUR: if (mode_btn) state <= SET_MIN;
        SET_MIN: begin
          if (mode_btn) begin
            state   <= RUN;
            sec_clr <= 1'b1;
          end
        end
        default: state <= mode_btn ? SET_HOUR : RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_min_hour_gen.sv
// Randomized and directed bench for min_hour_gen; the reference keeps time as
// minutes since midnight and derives the displayed fields from that.
module tb_min_hour_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, one_sec_tick = 1'b0, min_tic = 1'b0;
  logic       mode_btn = 1'b0, inc_btn = 1'b0;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] set_state;
  logic       sec_clr, hour_tic, day_tic;
`ifdef HOUR_12_MODE_EN
  logic       pm;
`endif

  int tests = 0;
  int failures = 0;

  int ref_tod;
  int ref_state;
  bit ref_sec_clr;

  min_hour_gen dut (
    .clk(clk), .reset(reset), .en(en), .one_sec_tick(one_sec_tick),
    .min_tic(min_tic), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .min(min), .hour(hour), .set_state(set_state), .sec_clr(sec_clr),
    .hour_tic(hour_tic), .day_tic(day_tic)
`ifdef HOUR_12_MODE_EN
    , .pm(pm)
`endif
  );

  always #5 clk = ~clk;

  function automatic int expHour(input int tod);
`ifdef HOUR_12_MODE_EN
    int h;
    h = (tod / 60) % 12;
    return (h == 0) ? 12 : h;
`else
    return tod / 60;
`endif
  endfunction

  // Hour set steps the displayed hour while keeping minutes and the am/pm half.
  function automatic int hourSet(input int tod);
`ifdef HOUR_12_MODE_EN
    int nh;
    int half;
    half = (tod >= 720) ? 12 : 0;
    nh = (expHour(tod) == 12) ? 1 : expHour(tod) + 1;
    return ((nh % 12) + half) * 60 + tod % 60;
`else
    return (((tod / 60) + 1) % 24) * 60 + tod % 60;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkRegs();
    checkOutput("min", 32'(min), ref_tod % 60);
    checkOutput("hour", 32'(hour), expHour(ref_tod));
    checkOutput("set_state", 32'(set_state), ref_state);
    checkOutput("sec_clr", 32'(sec_clr), int'(ref_sec_clr));
`ifdef HOUR_12_MODE_EN
    checkOutput("pm", 32'(pm), (ref_tod >= 720) ? 1 : 0);
`endif
  endtask

  task automatic modelReset();
    ref_tod = 0;
    ref_state = 0;
    ref_sec_clr = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check combinational tics, then registers after the edge.
  task automatic applyStimulus(input bit e, input bit t, input bit m, input bit mb, input bit ib);
    bit adv;
    bit at59;
    @(negedge clk);
    en = e; one_sec_tick = t; min_tic = m; mode_btn = mb; inc_btn = ib;
    #1;
    at59 = (ref_tod % 60) == 59;
    checkOutput("hour_tic", 32'(hour_tic), int'(m && at59));
    checkOutput("day_tic", 32'(day_tic), int'(m && at59 && (ref_tod / 60) == 23));
    adv = e && t && m;
    ref_sec_clr = (ref_state == 2) && mb;
    case (ref_state)
      1: begin
        if (ib) ref_tod = hourSet(ref_tod);
        if (mb) ref_state = 2;
      end
      2: begin
        if (ib) ref_tod = (ref_tod / 60) * 60 + ((ref_tod % 60) + 1) % 60;
        if (mb) ref_state = 0;
      end
      default: begin
        if (adv) ref_tod = (ref_tod + 1) % 1440;
        if (mb) ref_state = 1;
      end
    endcase
    @(posedge clk);
    #1;
    checkRegs();
  endtask

  task automatic goRun();
    for (int i = 0; i < 3 && ref_state != 0; i++) applyStimulus(0, 0, 0, 1, 0);
  endtask

  task automatic setTime(input int th, input int tm);
    goRun();
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 30 && expHour(ref_tod) != th; i++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 70 && (ref_tod % 60) != tm; i++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
  endtask

  initial begin
    int r;
    modelReset();
    #12;
    checkRegs();
    @(negedge clk);
    reset = 1'b1;

    // One hour of normal seconds traffic: the wrap level is held across the tick and an idle cycle.
    for (int m = 0; m < 60; m++) begin
      for (int s = 0; s < 60; s++) begin
        applyStimulus(1, 1, s == 59, 0, 0);
        applyStimulus(1, 0, s == 59, 0, 0);
      end
    end
    checkOutput("hour_after_60min", 32'(hour), 1);
    checkOutput("min_after_60min", 32'(min), 0);

    for (int i = 0; i < 60; i++) applyStimulus(1, 0, 1, 0, 0);
    checkOutput("min_tic_alone", 32'(min), 0);

`ifdef HOUR_12_MODE_EN
    setTime(11, 59);
    applyStimulus(1, 1, 1, 0, 0);
    setTime(12, 59);
    applyStimulus(1, 1, 1, 0, 0);
    setTime(11, 59);
    applyStimulus(1, 1, 1, 0, 0);
    setTime(10, 5);
`else
    setTime(23, 59);
    applyStimulus(1, 1, 1, 0, 0);
    setTime(22, 5);
`endif
    checkOutput("day_wrap_min", 32'(min), 5);

    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("set_hour_wrap", 32'(hour), 1);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 61; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("set_min_wrap", 32'(min), 6);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);

    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      applyStimulus(r[0] | r[1], r[2], r[3], r[7:4] == 4'd0, r[9:8] == 2'd0);
    end

    goRun();
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    modelReset();
    #1;
    checkRegs();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
